// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-state counter: counts stalled BUSY cycles and flags when the limit is reached.
module arb_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] HIT_VAL = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX_VAL = {CW{1'b1}};

    logic [CW-1:0] count;

    // Saturating: holds at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != MAX_VAL) begin
            count <= count + CW'(1);
        end
    end

    assign hit = (count == HIT_VAL);

endmodule

// File: rtl/mux_2x1_32bit.sv
// Two-input mux feeding the memory address and write-data buses.
module mux_2x1_32bit #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (0) and data (1) with a wait-state timeout.
// Build option: define ROUND_ROBIN_EN for round-robin on simultaneous requests (default: data wins).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant
);

    state_t state;
    logic   busy;
    logic   hit;
    logic   fire;
    logic   timed_out;
    logic   other_req;
    logic   winner;

    assign busy      = (state == BUSY);
    assign fire      = busy && (mem_ready || hit);
    assign timed_out = busy && !mem_ready && hit;
    assign other_req = (grant == REQ_DATA) ? req0 : req1;

    assign done0 = fire && (grant == REQ_FETCH);
    assign done1 = fire && (grant == REQ_DATA);
    assign err0  = done0 && timed_out;
    assign err1  = done1 && timed_out;
    assign rdata = (fire && mem_ready) ? mem_rdata : '0;

`ifdef ROUND_ROBIN_EN
    logic rr_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (fire) begin
            rr_last <= grant;
        end
    end

    always_comb begin
        winner = REQ_DATA;
        if (!req1) begin
            winner = REQ_FETCH;
        end else if (req0) begin
            winner = !rr_last;
        end
    end
`else
    assign winner = req1 ? REQ_DATA : REQ_FETCH;
`endif

    // Completion with the other side waiting hands over directly; otherwise drop to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= REQ_FETCH;
            mem_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= BUSY;
                        grant   <= winner;
                        mem_req <= 1'b1;
                    end
                end
                BUSY: begin
                    if (fire) begin
                        if (other_req) begin
                            grant <= !grant;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    arb_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy || fire),
        .en    (busy && !mem_ready),
        .hit   (hit)
    );

    mux_2x1_32bit #(
        .W (ADDR_W)
    ) u_addr_mux (
        .sel (grant),
        .d0  (addr0),
        .d1  (addr1),
        .y   (mem_addr)
    );

    mux_2x1_32bit #(
        .W (DATA_W)
    ) u_wdata_mux (
        .sel (grant),
        .d0  (wdata0),
        .d1  (wdata1),
        .y   (mem_wdata)
    );

    assign mem_we = grant ? we1 : we0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (TIMEOUT=4); expectations adapt to ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int TO = 4;

    typedef struct packed {
        logic        who;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        we0, we1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        grant;

    exp_t sb[$];
    int   tests;
    int   fails;
    logic last_served;
    logic first;
    logic exp_g;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .we0       (we0),
        .we1       (we1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .done0     (done0),
        .done1     (done1),
        .err0      (err0),
        .err1      (err1),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every done pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done0 || done1) begin
            check("done_excl", {31'd0, done0 && done1}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_who", {31'd0, done1}, {31'd0, e.who});
                check("done_err", {31'd0, done1 ? err1 : err0}, {31'd0, e.err});
                check("done_rdata", rdata, e.rdata);
                last_served = done1;
            end
        end else begin
            check("idle_rdata", rdata, 32'd0);
            check("idle_err", {31'd0, err0 | err1}, 32'd0);
        end
    end

    initial begin
        tests = 0; fails = 0; last_served = 1'b1;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; we0 = 0; we1 = 0;
        wdata0 = 0; wdata1 = 0; mem_ready = 0; mem_rdata = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_err", {30'd0, err1, err0}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single fetch read, ready two cycles after mem_req rises
        req0 = 1; addr0 = 32'h0000_0040; we0 = 0;
        sb.push_back('{who: 1'b0, err: 1'b0, rdata: 32'hDEAD_BEEF});
        check("t1_pre_req", {31'd0, mem_req}, 32'd0);
        step();
        check("t1_mem_req", {31'd0, mem_req}, 32'd1);
        check("t1_grant", {31'd0, grant}, 32'd0);
        check("t1_addr", mem_addr, 32'h0000_0040);
        step();
        step();
        mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
        #1 check("t1_done0", {31'd0, done0}, 32'd1);
        step();
        req0 = 0; mem_ready = 0;
        check("t1_done_pulse", {31'd0, done0}, 32'd0);
        check("t1_idle", {31'd0, mem_req}, 32'd0);

        // mem_ready while IDLE is ignored
        mem_ready = 1;
        #1 check("idle_ready_done", {30'd0, done1, done0}, 32'd0);
        step();
        mem_ready = 0;
        check("idle_ready_req", {31'd0, mem_req}, 32'd0);

        // Simultaneous requests, back-to-back handover
`ifdef ROUND_ROBIN_EN
        first = !last_served;
`else
        first = 1'b1;
`endif
        req0 = 1; req1 = 1; addr0 = 32'h200; addr1 = 32'h300;
        sb.push_back('{who: first, err: 1'b0, rdata: 32'hA5A5_0001});
        sb.push_back('{who: !first, err: 1'b0, rdata: 32'h5A5A_0002});
        step();
        check("t2_grant_first", {31'd0, grant}, {31'd0, first});
        check("t2_addr_first", mem_addr, first ? 32'h300 : 32'h200);
        step();
        mem_ready = 1; mem_rdata = 32'hA5A5_0001;
        step();
        mem_ready = 0;
        if (first) req1 = 0; else req0 = 0;
        check("t2_grant_flip", {31'd0, grant}, {31'd0, !first});
        check("t2_no_bubble", {31'd0, mem_req}, 32'd1);
        check("t2_addr_second", mem_addr, first ? 32'h200 : 32'h300);
        step();
        mem_ready = 1; mem_rdata = 32'h5A5A_0002;
        step();
        mem_ready = 0; req0 = 0; req1 = 0;
        check("t2_idle", {31'd0, mem_req}, 32'd0);
        step();

        // After reset, both held for four accesses
        rst_n = 0;
        step();
        rst_n = 1; last_served = 1'b1;
        step();
`ifdef ROUND_ROBIN_EN
        first = 1'b0;
`else
        first = 1'b1;
`endif
        exp_g = first;
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20;
        step();
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{who: exp_g, err: 1'b0, rdata: 32'h3000_0000 + i});
            check("t3_grant", {31'd0, grant}, {31'd0, exp_g});
            check("t3_mem_req", {31'd0, mem_req}, 32'd1);
            step();
            if (i == 3) begin
                if (exp_g) req0 = 0; else req1 = 0;
            end
            mem_ready = 1; mem_rdata = 32'h3000_0000 + i;
            step();
            mem_ready = 0;
            exp_g = !exp_g;
        end
        req0 = 0; req1 = 0;
        check("t3_idle", {31'd0, mem_req}, 32'd0);
        step();

        // Timeout: mem_ready never arrives
        req1 = 1; addr1 = 32'h80; we1 = 0; mem_rdata = 32'hFFFF_FFFF;
        sb.push_back('{who: 1'b1, err: 1'b1, rdata: 32'h0});
        step();
        for (int k = 0; k < TO - 1; k++) begin
            check("t4_early", {31'd0, done1}, 32'd0);
            step();
        end
        check("t4_done1", {31'd0, done1}, 32'd1);
        check("t4_err1", {31'd0, err1}, 32'd1);
        check("t4_rdata", rdata, 32'd0);
        step();
        req1 = 0; mem_rdata = 0;
        check("t4_idle", {31'd0, mem_req}, 32'd0);
        step();

        // Reset in the middle of an access
        req1 = 1; addr1 = 32'h400;
        step();
        check("t5_grant_pre", {31'd0, grant}, 32'd1);
        step();
        rst_n = 0;
        #1;
        check("t5_mem_req", {31'd0, mem_req}, 32'd0);
        check("t5_grant", {31'd0, grant}, 32'd0);
        req1 = 0;
        step();
        rst_n = 1; last_served = 1'b1;
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        #1 check("t5_late_ready", {30'd0, done1, done0}, 32'd0);
        step();
        mem_ready = 0; mem_rdata = 0;
        step();

        // Data-side write
        req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h1234_5678;
        we0 = 0; addr0 = 32'hCAFE_0000; wdata0 = 32'h8765_4321;
        sb.push_back('{who: 1'b1, err: 1'b0, rdata: 32'h0});
        step();
        check("t6_mem_we", {31'd0, mem_we}, 32'd1);
        check("t6_wdata", mem_wdata, 32'h1234_5678);
        check("t6_addr", mem_addr, 32'h100);
        mem_ready = 1;
        step();
        mem_ready = 0; req1 = 0; we1 = 0;
        step();
        check("t6_idle", {31'd0, mem_req}, 32'd0);
        check("t6_we_mux", {31'd0, mem_we}, 32'd0);

        step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
